redun_normalize: RTL and testbench

- Sequential normaliser that turns a redundant-form operand (NUM_WRDS words of WRD_BITS+1 bits, word i weighted 2^(i*WRD_BITS)) into canonical binary.
- Carries are resolved LANES words per cycle, and an optional conditional subtraction of modulus P follows.
- Sits at the output of the redundant Montgomery squarer, ahead of the msu result path.
- Replaces the one-shot combinational equalize/from_redun conversion with a pipelined, width- and throughput-parametrised block.

---
 rtl/redun_normalize.sv | 158 +++++++++++++++
 tb/tb_redun_normalize.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/redun_normalize.sv
// Sequential normaliser: resolves redundant-form carries LANES words per cycle,
// then optionally applies one conditional subtraction of modulus P.
module redun_normalize #(
    parameter int unsigned WRD_BITS  = 16,
    parameter int unsigned NUM_WRDS  = 65,
    parameter int unsigned LANES     = 4,
    parameter bit          REDUCE_EN = 1'b1,
    parameter logic [NUM_WRDS*WRD_BITS-1:0] P = {16'h8F3C, {63{16'hA5C3}}, 16'h2B71}
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic [NUM_WRDS*(WRD_BITS+1)-1:0]    i_dat,
    input  logic                                i_val,
    output logic                                o_rdy,
    output logic [NUM_WRDS*WRD_BITS-1:0]        o_dat,
    output logic                                o_ovf,
    output logic                                o_val,
    input  logic                                i_rdy
);

    localparam int unsigned WB1      = WRD_BITS + 1;
    localparam int unsigned SW       = WRD_BITS + 2;
    localparam int unsigned DAT_BITS = NUM_WRDS * WRD_BITS;
    localparam int unsigned K        = (NUM_WRDS + LANES - 1) / LANES;
    localparam int unsigned NPAD     = K * LANES;
    localparam int unsigned NLAST    = LANES - (NPAD - NUM_WRDS);
    localparam int unsigned CH       = LANES * WRD_BITS;
    localparam int unsigned CH1      = LANES * WB1;
    localparam int unsigned RES_W    = NPAD * WRD_BITS;
    localparam int unsigned WRD_W    = NPAD * WB1;
    localparam int unsigned CW       = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(K - 1);
    localparam logic [RES_W-1:0] P_PAD    = RES_W'(P);

    typedef enum logic [1:0] {S_IDLE, S_PROP, S_SUB, S_DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [WRD_W-1:0]      r_wrd;
    logic [RES_W-1:0]      r_res, r_dif;
    logic [1:0]            r_c, r_ctop;
    logic                  r_b;
    logic [CW-1:0]         r_cnt;
    logic [DAT_BITS-1:0]   r_odat;
    logic                  r_ovf;

    logic                  w_last;
    logic [CH-1:0]         w_pch, w_rch, w_sch, w_dch;
    logic [1:0]            w_c_nxt;
    logic                  w_b_nxt;
    logic [RES_W-1:0]      w_res_nxt, w_dif_nxt;
    logic                  w_bfin;
    logic [1:0]            w_dtop;
    logic [SW-1:0]         w_s;
    logic [WB1-1:0]        w_d;

    assign w_last = (r_cnt == CNT_LAST);
    assign o_rdy  = (r_state == S_IDLE);
    assign o_val  = (r_state == S_DONE);
    assign o_dat  = r_odat;
    assign o_ovf  = r_ovf;

    // Word data is streamed through shift registers so every cycle works on the
    // low LANES words; padding lanes of the final chunk are skipped by the chains.
    always_comb begin
        w_pch   = CH'(P_PAD >> (32'(r_cnt) * CH));
        w_rch   = r_res[CH-1:0];
        w_sch   = '0;
        w_dch   = '0;
        w_c_nxt = r_c;
        w_b_nxt = r_b;
        w_s     = '0;
        w_d     = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (!w_last || l < NLAST) begin
                w_s = SW'(r_wrd[l*WB1 +: WB1]) + SW'(w_c_nxt);
                w_sch[l*WRD_BITS +: WRD_BITS] = w_s[WRD_BITS-1:0];
                w_c_nxt = w_s[SW-1:WRD_BITS];
                w_d = {1'b0, w_rch[l*WRD_BITS +: WRD_BITS]}
                    - {1'b0, w_pch[l*WRD_BITS +: WRD_BITS]} - WB1'(w_b_nxt);
                w_dch[l*WRD_BITS +: WRD_BITS] = w_d[WRD_BITS-1:0];
                w_b_nxt = w_d[WRD_BITS];
            end
        end
        w_res_nxt = (r_res >> CH) | (RES_W'((r_state == S_SUB) ? w_rch : w_sch) << (RES_W - CH));
        w_dif_nxt = (r_dif >> CH) | (RES_W'(w_dch) << (RES_W - CH));
        w_bfin    = (r_ctop < {1'b0, w_b_nxt});
        w_dtop    = r_ctop - {1'b0, w_b_nxt};
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_val)  w_state_nxt = S_PROP;
            S_PROP: if (w_last) w_state_nxt = REDUCE_EN ? S_SUB : S_DONE;
            S_SUB:  if (w_last) w_state_nxt = S_DONE;
            S_DONE: if (i_rdy)  w_state_nxt = S_IDLE;
            default:            w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_c    <= '0;
            r_b    <= 1'b0;
            r_ctop <= '0;
            r_cnt  <= '0;
            r_odat <= '0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_val) begin
                        r_wrd <= WRD_W'(i_dat);
                        r_c   <= '0;
                        r_cnt <= '0;
                    end
                end
                S_PROP: begin
                    r_wrd <= r_wrd >> CH1;
                    r_res <= w_res_nxt;
                    r_c   <= w_c_nxt;
                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    if (w_last) begin
                        r_ctop <= w_c_nxt;
                        r_b    <= 1'b0;
                        if (!REDUCE_EN) begin
                            r_odat <= w_res_nxt[DAT_BITS-1:0];
                            r_ovf  <= (w_c_nxt != 2'd0);
                        end
                    end
                end
                S_SUB: begin
                    // R rotates a full turn and is back in place after the last chunk
                    r_res <= w_res_nxt;
                    r_dif <= w_dif_nxt;
                    r_b   <= w_b_nxt;
                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    if (w_last) begin
                        if (w_bfin) begin
                            r_odat <= w_res_nxt[DAT_BITS-1:0];
                            r_ovf  <= (r_ctop != 2'd0);
                        end else begin
                            r_odat <= w_dif_nxt[DAT_BITS-1:0];
                            r_ovf  <= (w_dtop != 2'd0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_redun_normalize.sv
// Randomised and directed checks of redun_normalize across several LANES /
// REDUCE_EN configurations against an arbitrary-precision arithmetic model.
module tb_redun_normalize;

    localparam int unsigned WB = 16;
    localparam int unsigned NW = 65;
    localparam int unsigned IW = NW * (WB + 1);
    localparam int unsigned DW = NW * WB;
    localparam int unsigned MW = DW + 4;
    localparam int unsigned NI = 5;
    localparam logic [DW-1:0] P_MOD = {16'h8F3C, {63{16'hA5C3}}, 16'h2B71};

    function automatic int unsigned lanes_of(input int unsigned g);
        return (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 13 : (g == 3) ? 65 : 4;
    endfunction

    function automatic bit red_of(input int unsigned g);
        return (g != 4);
    endfunction

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] i_dat = '0;
    logic          r_vl  [NI];
    logic          r_rd  [NI];
    logic          w_rdy [NI];
    logic          w_val [NI];
    logic          w_ovf [NI];
    logic [DW-1:0] w_odat [NI];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        redun_normalize #(
            .WRD_BITS (WB),
            .NUM_WRDS (NW),
            .LANES    (lanes_of(g)),
            .REDUCE_EN(red_of(g)),
            .P        (P_MOD)
        ) u_dut (
            .i_clk(clk),
            .i_rst(rst),
            .i_dat(i_dat),
            .i_val(r_vl[g]),
            .o_rdy(w_rdy[g]),
            .o_dat(w_odat[g]),
            .o_ovf(w_ovf[g]),
            .o_val(w_val[g]),
            .i_rdy(r_rd[g])
        );
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        int unsigned w;
        bit found;
        n_vec++;
        if (got !== exp) begin
            w = 0;
            found = 1'b0;
            for (int unsigned i = 0; i < NW; i++)
                if (!found && got[i*WB +: WB] !== exp[i*WB +: WB]) begin
                    w = i;
                    found = 1'b1;
                end
            n_err++;
            $display("FAIL %s: word %0d got %h expected %h", tag, w, got[w*WB +: WB], exp[w*WB +: WB]);
        end
    endtask

    // Value of the redundant operand, optionally reduced once by P.
    task automatic model(input bit red, input logic [IW-1:0] op,
                         output logic [DW-1:0] d, output logic o);
        logic [MW-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NW; i++)
            v = v + (MW'(op[i*(WB+1) +: WB+1]) << (i * WB));
        if (red && v >= MW'(P_MOD))
            v = v - MW'(P_MOD);
        d = v[DW-1:0];
        o = |v[MW-1:DW];
    endtask

    function automatic logic [IW-1:0] to_redun(input logic [MW-1:0] v);
        logic [IW-1:0] op;
        op = '0;
        for (int unsigned i = 0; i < NW - 1; i++)
            op[i*(WB+1) +: WB+1] = {1'b0, v[i*WB +: WB]};
        op[(NW-1)*(WB+1) +: WB+1] = v[(NW-1)*WB +: WB+1];
        return op;
    endfunction

    task automatic run_op(input int unsigned g, input logic [IW-1:0] op, input int unsigned hold);
        logic [DW-1:0] ed;
        logic          eo;
        int unsigned   lat, k, el;
        string         t;
        t  = $sformatf("g%0d", g);
        k  = (NW + lanes_of(g) - 1) / lanes_of(g);
        el = k * (red_of(g) ? 2 : 1);
        model(red_of(g), op, ed, eo);
        @(negedge clk);
        r_rd[g] = 1'b0;
        check({t, "_rdy_idle"}, DW'(w_rdy[g]), DW'(1));
        i_dat   = op;
        r_vl[g] = 1'b1;
        @(posedge clk);
        #1 r_vl[g] = 1'b0;
        lat = 0;
        while (!w_val[g] && lat < 400) begin
            @(posedge clk);
            #1 lat++;
        end
        check({t, "_latency"}, DW'(lat), DW'(el));
        check({t, "_dat"}, w_odat[g], ed);
        check({t, "_ovf"}, DW'(w_ovf[g]), DW'(eo));
        check({t, "_rdy_busy"}, DW'(w_rdy[g]), DW'(0));
        for (int unsigned c = 0; c < hold; c++) begin
            @(negedge clk);
            i_dat   = {$urandom, $urandom, $urandom};
            r_vl[g] = 1'b1;
            @(posedge clk);
            #1;
            check({t, "_hold_val"}, DW'(w_val[g]), DW'(1));
            check({t, "_hold_rdy"}, DW'(w_rdy[g]), DW'(0));
            check({t, "_hold_dat"}, w_odat[g], ed);
        end
        @(negedge clk);
        r_vl[g] = 1'b0;
        r_rd[g] = 1'b1;
        @(posedge clk);
        #1;
        check({t, "_drop_val"}, DW'(w_val[g]), DW'(0));
        check({t, "_back_rdy"}, DW'(w_rdy[g]), DW'(1));
    endtask

    function automatic logic [IW-1:0] rand_op(input int unsigned mode);
        logic [IW-1:0] op;
        op = '0;
        for (int unsigned i = 0; i < NW; i++)
            case (mode)
                0:       op[i*(WB+1) +: WB+1] = 17'($urandom_range(0, 17'h1FFFF));
                1:       op[i*(WB+1) +: WB+1] = 17'($urandom_range(0, 16'hFFFF));
                default: op[i*(WB+1) +: WB+1] = ($urandom_range(0, 3) == 0) ? 17'h1FFFF : 17'h0;
            endcase
        return op;
    endfunction

    initial begin
        logic [IW-1:0] op;
        logic [MW-1:0] pv;
        bit            seen;
        for (int unsigned g = 0; g < NI; g++) begin
            r_vl[g] = 1'b0;
            r_rd[g] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        for (int unsigned g = 0; g < NI; g++) begin
            check($sformatf("g%0d_rst_rdy", g), DW'(w_rdy[g]), DW'(1));
            check($sformatf("g%0d_rst_val", g), DW'(w_val[g]), DW'(0));
            check($sformatf("g%0d_rst_dat", g), w_odat[g], '0);
            check($sformatf("g%0d_rst_ovf", g), DW'(w_ovf[g]), DW'(0));
        end

        run_op(1, '0, 0);

        op = '0;
        for (int unsigned i = 0; i < NW - 1; i++) op[i*(WB+1) +: WB+1] = 17'h1FFFF;
        run_op(4, op, 0);
        op = '0;
        op[(NW-1)*(WB+1) +: WB+1] = 17'h1FFFF;
        run_op(4, op, 0);

        pv = MW'(P_MOD);
        run_op(1, to_redun(pv), 0);
        run_op(1, to_redun(pv - 1), 0);
        run_op(1, to_redun(2 * pv - 1), 0);

        run_op(1, rand_op(0), 10);
        run_op(1, rand_op(1), 0);

        // Abort mid-carry-resolution
        @(negedge clk);
        i_dat   = rand_op(0);
        r_vl[1] = 1'b1;
        @(posedge clk);
        #1 r_vl[1] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_rdy", DW'(w_rdy[1]), DW'(1));
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        repeat (60) begin
            @(posedge clk);
            #1 seen |= w_val[1];
        end
        check("rst_mid_no_val", DW'(seen), DW'(0));
        run_op(1, rand_op(0), 0);

        for (int unsigned g = 0; g < NI; g++)
            for (int unsigned n = 0; n < 6; n++)
                run_op(g, rand_op(n % 3), (n == 2) ? 2 : 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
